// File: rtl/pixel_word_packer.sv
// Packs 8-bit filtered pixels into little-endian 32-bit words and writes them
// to frame memory at consecutive word addresses, padding each row's last word.
module pixel_word_packer #(
  parameter int                IMG_WIDTH  = 320,
  parameter int                IMG_HEIGHT = 240,
  parameter int                ADDR_W     = 17,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        pixel_in,
  input  logic              pixel_valid,
  output logic              pixel_ready,
  output logic [31:0]       wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  input  logic              wr_ack,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [8:0] LAST_COL = 9'(IMG_WIDTH - 1);
  localparam logic [8:0] LAST_ROW = 9'(IMG_HEIGHT - 1);

  state_t            state_q, state_d;
  logic [8:0]        col_q, col_d;
  logic [8:0]        row_q, row_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_word_q, last_word_d;
  logic              pixel_ready_q, pixel_ready_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              row_end_s;

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    byte_idx_d    = byte_idx_q;
    word_d        = word_q;
    addr_d        = addr_q;
    last_word_d   = last_word_q;
    pixel_ready_d = pixel_ready_q;
    wr_en_d       = wr_en_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    row_end_s     = (col_q == LAST_COL);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_COLLECT;
          addr_d        = BASE_ADDR;
          col_d         = 9'd0;
          row_d         = 9'd0;
          byte_idx_d    = 2'd0;
          word_d        = 32'd0;
          last_word_d   = 1'b0;
          pixel_ready_d = 1'b1;
          busy_d        = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (pixel_valid) begin
          word_d[{byte_idx_q, 3'b000} +: 8] = pixel_in;
          if (row_end_s) begin
            col_d      = 9'd0;
            byte_idx_d = 2'd0;
            row_d      = row_q + 9'd1;
          end else begin
            col_d      = col_q + 9'd1;
            byte_idx_d = byte_idx_q + 2'd1;
          end
          // A full word or the row's final pixel flushes the word register
          if ((byte_idx_q == 2'd3) || row_end_s) begin
            state_d       = ST_WRITE;
            pixel_ready_d = 1'b0;
            wr_en_d       = 1'b1;
            last_word_d   = row_end_s && (row_q == LAST_ROW);
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_WRITE: begin
        if (wr_ack) begin
          addr_d  = addr_q + ADDR_W'(1);
          word_d  = 32'd0;
          wr_en_d = 1'b0;
          if (last_word_q) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d       = ST_COLLECT;
            pixel_ready_d = 1'b1;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d       = ST_IDLE;
        pixel_ready_d = 1'b0;
        wr_en_d       = 1'b0;
        busy_d        = 1'b0;
      end
    endcase
  end

  // State, counters, word register and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      col_q         <= 9'd0;
      row_q         <= 9'd0;
      byte_idx_q    <= 2'd0;
      word_q        <= 32'd0;
      addr_q        <= BASE_ADDR;
      last_word_q   <= 1'b0;
      pixel_ready_q <= 1'b0;
      wr_en_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      byte_idx_q    <= byte_idx_d;
      word_q        <= word_d;
      addr_q        <= addr_d;
      last_word_q   <= last_word_d;
      pixel_ready_q <= pixel_ready_d;
      wr_en_q       <= wr_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign pixel_ready = pixel_ready_q;
  assign wr_data     = word_q;
  assign wr_addr     = addr_q;
  assign wr_en       = wr_en_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_pixel_word_packer.sv
// Bench for pixel_word_packer: three instances with different geometry, random
// and table stimulus, checked against a row/word arithmetic model of the frame.
module tb_pixel_word_packer;

  localparam int NI = 3;

  function automatic int w_of(input int i);
    return (i == 0) ? 8 : (i == 1) ? 6 : 1;
  endfunction
  function automatic int h_of(input int i);
    return (i == 2) ? 3 : 2;
  endfunction
  function automatic logic [16:0] b_of(input int i);
    return (i == 0) ? 17'h00000 : (i == 1) ? 17'h00100 : 17'h1FFFF;
  endfunction

  logic        clk = 1'b0;
  logic        reset_s       [NI];
  logic        start_s       [NI];
  logic [7:0]  pixel_in_s    [NI];
  logic        pixel_valid_s [NI];
  logic        pixel_ready_s [NI];
  logic [31:0] wr_data_s     [NI];
  logic [16:0] wr_addr_s     [NI];
  logic        wr_en_s       [NI];
  logic        wr_ack_s      [NI];
  logic        busy_s        [NI];
  logic        done_s        [NI];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int amode [NI];

  logic [31:0] got_d [NI][0:255];
  logic [16:0] got_a [NI][0:255];
  int          got_n [NI];
  int          done_n [NI];
  int          done_cyc [NI];
  int          last_ack_cyc [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pixel_word_packer #(
      .IMG_WIDTH (w_of(g)),
      .IMG_HEIGHT(h_of(g)),
      .ADDR_W    (17),
      .BASE_ADDR (b_of(g))
    ) dut (
      .clk        (clk),
      .reset      (reset_s[g]),
      .start      (start_s[g]),
      .pixel_in   (pixel_in_s[g]),
      .pixel_valid(pixel_valid_s[g]),
      .pixel_ready(pixel_ready_s[g]),
      .wr_data    (wr_data_s[g]),
      .wr_addr    (wr_addr_s[g]),
      .wr_en      (wr_en_s[g]),
      .wr_ack     (wr_ack_s[g]),
      .busy       (busy_s[g]),
      .done       (done_s[g])
    );
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side responder: always ack, random ack, or ack after three stall cycles
  initial begin
    int hold [NI];
    for (int i = 0; i < NI; i++) begin
      wr_ack_s[i] = 1'b0;
      hold[i] = 0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NI; i++) begin
        case (amode[i])
          0: wr_ack_s[i] = 1'b1;
          1: wr_ack_s[i] = 1'($urandom_range(0, 1));
          default: begin
            if (wr_en_s[i]) begin
              wr_ack_s[i] = (hold[i] == 3);
              hold[i]++;
            end else begin
              wr_ack_s[i] = 1'b0;
              hold[i] = 0;
            end
          end
        endcase
      end
    end
  end

  // Write monitor: logs transfers, checks hold stability and done behaviour
  initial begin
    logic        prev_hold [NI];
    logic [31:0] prev_d    [NI];
    logic [16:0] prev_a    [NI];
    int          en_len    [NI];
    for (int i = 0; i < NI; i++) begin
      prev_hold[i] = 1'b0;
      en_len[i] = 0;
      got_n[i] = 0;
      done_n[i] = 0;
      done_cyc[i] = 0;
      last_ack_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (wr_en_s[i] === 1'b1) begin
          check_val("ready_low_in_write", pixel_ready_s[i], 1'b0);
          if (prev_hold[i]) begin
            check_val("hold_data", wr_data_s[i], prev_d[i]);
            check_val("hold_addr", wr_addr_s[i], prev_a[i]);
          end
          en_len[i]++;
          prev_d[i] = wr_data_s[i];
          prev_a[i] = wr_addr_s[i];
          prev_hold[i] = !wr_ack_s[i];
          if (wr_ack_s[i]) begin
            if (amode[i] == 2) check_val("stall_len", en_len[i], 4);
            if (got_n[i] < 256) begin
              got_d[i][got_n[i]] = wr_data_s[i];
              got_a[i][got_n[i]] = wr_addr_s[i];
            end
            got_n[i]++;
            last_ack_cyc[i] = cyc;
            en_len[i] = 0;
          end
        end else begin
          prev_hold[i] = 1'b0;
          en_len[i] = 0;
        end
        if (done_s[i] === 1'b1) begin
          check_val("done_busy", busy_s[i], 1'b0);
          check_val("done_ready", pixel_ready_s[i], 1'b0);
          done_n[i]++;
          done_cyc[i] = cyc;
        end
      end
    end
  end

  task automatic apply_reset(input int i);
    @(posedge clk);
    #2;
    reset_s[i] = 1'b1;
    @(posedge clk);
    #2;
    check_val("rst_ready", pixel_ready_s[i], 1'b0);
    check_val("rst_wr_en", wr_en_s[i], 1'b0);
    check_val("rst_wr_data", wr_data_s[i], 32'h0);
    check_val("rst_wr_addr", wr_addr_s[i], b_of(i));
    check_val("rst_busy", busy_s[i], 1'b0);
    check_val("rst_done", done_s[i], 1'b0);
    reset_s[i] = 1'b0;
  endtask

  // vmode: 0 continuous, 1 every other cycle, 2 random; abort_n>0 resets after that many pixels
  task automatic run_frame(input int i, input int vmode, input int am, input bit rnd,
                           input bit mid_start, input int abort_n);
    logic [7:0]  pix [0:63];
    logic [31:0] d;
    int w, h, np, lim, k, budget, base_n, base_done, e;
    bit v, tog;
    w = w_of(i);
    h = h_of(i);
    np = w * h;
    for (int p = 0; p < np; p++) pix[p] = rnd ? 8'($urandom) : 8'(p + 1);
    lim = (abort_n > 0) ? abort_n : np;
    base_n = got_n[i];
    base_done = done_n[i];
    amode[i] = am;
    k = 0;
    budget = 0;
    tog = 1'b1;
    @(posedge clk);
    #2;
    start_s[i] = 1'b1;
    @(posedge clk);
    #2;
    start_s[i] = 1'b0;
    check_val("start_busy", busy_s[i], 1'b1);
    check_val("start_ready", pixel_ready_s[i], 1'b1);
    while (k < lim && budget < 2000) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = !tog;
      pixel_valid_s[i] = v;
      pixel_in_s[i] = v ? pix[k] : 8'($urandom);
      start_s[i] = mid_start && (k == 5);
      if (v && pixel_ready_s[i]) k++;
      @(posedge clk);
      #2;
      budget++;
    end
    pixel_valid_s[i] = 1'b0;
    start_s[i] = 1'b0;
    check_val("pixel_budget", budget < 2000, 1'b1);
    if (abort_n > 0) begin
      apply_reset(i);
      repeat (8) @(posedge clk);
      #2;
      check_val("abort_writes", got_n[i] - base_n, abort_n / 4);
      check_val("abort_no_done", done_n[i] - base_done, 0);
      check_val("abort_idle", busy_s[i], 1'b0);
      return;
    end
    budget = 0;
    while (done_n[i] == base_done && budget < 2000) begin
      @(posedge clk);
      #2;
      budget++;
    end
    check_val("done_budget", budget < 2000, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    check_val("done_count", done_n[i] - base_done, 1);
    check_val("done_latency", done_cyc[i] - last_ack_cyc[i], 1);
    check_val("idle_busy", busy_s[i], 1'b0);
    check_val("idle_ready", pixel_ready_s[i], 1'b0);
    e = 0;
    for (int r = 0; r < h; r++) begin
      for (int wd = 0; wd < (w + 3) / 4; wd++) begin
        d = 32'h0;
        for (int b = 0; b < 4; b++) begin
          if (wd * 4 + b < w) d[8*b +: 8] = pix[r * w + wd * 4 + b];
        end
        if (base_n + e < 256) begin
          check_val("word_data", got_d[i][base_n + e], d);
          check_val("word_addr", got_a[i][base_n + e], 17'(b_of(i) + 17'(e)));
        end
        e++;
      end
    end
    check_val("word_count", got_n[i] - base_n, e);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      reset_s[i] = 1'b1;
      start_s[i] = 1'b0;
      pixel_valid_s[i] = 1'b0;
      pixel_in_s[i] = 8'h00;
      amode[i] = 0;
    end
    repeat (3) @(posedge clk);
    for (int i = 0; i < NI; i++) apply_reset(i);

    run_frame(0, 0, 0, 1'b0, 1'b0, 0);
    run_frame(0, 1, 0, 1'b0, 1'b0, 0);
    run_frame(1, 0, 0, 1'b0, 1'b0, 0);
    run_frame(0, 0, 2, 1'b0, 1'b0, 0);
    run_frame(0, 0, 0, 1'b0, 1'b1, 0);
    run_frame(0, 0, 0, 1'b0, 1'b0, 5);
    run_frame(0, 0, 0, 1'b0, 1'b0, 0);
    run_frame(2, 0, 0, 1'b0, 1'b0, 0);
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < NI; i++) run_frame(i, 2, 1, 1'b1, 1'b0, 0);
    end
    run_frame(1, 1, 2, 1'b1, 1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_word_packer.md
Name: pixel_word_packer

Overview:
- Write-side counterpart to the camera line buffers. It accepts the filter pipeline's 8-bit result pixels one at a time and packs them into 32-bit little-endian words.
- Issues sequential word writes into the output frame memory, so frames are stored in the same byte/word layout the line buffers consume: byte k of a word holds bits [8k+7:8k], and the lowest-addressed pixel sits in bits [7:0].
- Tracks row and column, pads a partial final word at each row end, and signals frame completion.

Parameters:
- IMG_WIDTH, 320, pixels per row (1..512).
- IMG_HEIGHT, 240, rows per frame (1..512).
- ADDR_W, 17, width of the word write address.
- BASE_ADDR, 0, word address of the first frame word.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; begins a frame when idle.
- pixel_in  input  8  filtered pixel value.
- pixel_valid  input  1  pixel_in is valid this cycle.
- pixel_ready  output  1  packer can accept a pixel this cycle.
- wr_data  output  32  packed word to memory.
- wr_addr  output  ADDR_W  word address of wr_data.
- wr_en  output  1  write request, held until acknowledged.
- wr_ack  input  1  memory accepted the write this cycle.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse after the last word of the frame is acknowledged.

Behaviour:
- Reset values: pixel_ready=0, wr_en=0, wr_data=0, wr_addr=BASE_ADDR, busy=0, done=0.
- Reset also returns the FSM to IDLE and clears the column, row and byte counters and the word register.
- Reset mid-frame abandons the frame. No done is produced and no further writes are issued.
- States:
  - IDLE: pixel_ready=0, busy=0. On start, go to COLLECT, load wr_addr=BASE_ADDR and clear the counters.
  - COLLECT: pixel_ready=1, busy=1.
  - WRITE: pixel_ready=0, wr_en=1, busy=1.
  - DONE: busy=0, done=1 for exactly one cycle, then IDLE.
- Pixel acceptance:
  - A pixel is accepted on a rising edge where pixel_valid && pixel_ready.
  - The pixel is written into byte lane byte_idx of the word register, and byte_idx then increments.
  - The column counter increments on every accepted pixel.
- Word completion: when the accepted pixel fills lane 3 or is the last pixel of the row (col==IMG_WIDTH-1), go to WRITE.
  - wr_data is presented from the next cycle.
  - Unfilled upper lanes are zero (register cleared after each write).
  - At row end the column and byte_idx reset to 0, and row increments.
- Write handshake:
  - wr_data and wr_addr are stable while wr_en=1.
  - A transfer completes on a rising edge with wr_en && wr_ack. wr_ack may be high in the first wr_en cycle, giving a 1-cycle WRITE.
  - wr_ack is ignored when wr_en=0.
  - After the ack, wr_addr increments by 1 (wraps modulo 2^ADDR_W) and the word register clears.
  - If that word was the last word of the last row, go to DONE; otherwise return to COLLECT.
- Addressing: strictly linear. Words per row = ceil(IMG_WIDTH/4), and no gaps between rows.
- Minimum latency: 4th byte accepted at edge N → wr_en=1 from N+1. With an immediate ack, pixel_ready is high again at N+2.
- Sustained rate is 4 pixels per 5 cycles with a zero-latency ack.
- start is ignored while busy or in DONE.
- pixel_valid outside COLLECT has no effect; the pixel is not consumed.
- Counters: column and row use 9 bits each; byte_idx uses 2 bits.
- IMG_WIDTH=1 yields one write per row with only lane 0 populated.

Test Plan:
- IMG_WIDTH=8, IMG_HEIGHT=2, BASE_ADDR=0, wr_ack tied high, continuous pixels 0x01..0x10 → writes in order:
  - 0x04030201@0, 0x08070605@1, 0x0C0B0A09@2, 0x100F0E0D@3.
  - done pulses once, 1 cycle after the last ack, and busy then falls.
- IMG_WIDTH=6, IMG_HEIGHT=2, BASE_ADDR=0x100, pixels 0x01..0x0C → writes in order:
  - 0x04030201@0x100, 0x00000605@0x101, 0x0A090807@0x102, 0x00000C0B@0x103.
- Backpressure: wr_ack held low 3 cycles after wr_en rises → wr_en, wr_data and wr_addr stay constant for 4 cycles and pixel_ready=0 throughout. Exactly one write is counted, and the next address is +1.
- Sparse pixel_valid (toggling every other cycle) → identical write sequence to the first test, and no pixel is duplicated or dropped.
- start pulsed mid-frame → ignored, and the address sequence continues. reset asserted after 5 of 16 pixels → all outputs at reset values the next cycle and no done. A fresh start then restarts at BASE_ADDR with lane 0.
- Last word of the frame acked in the same cycle wr_en first rises → done on the following cycle, with pixel_ready=0 in DONE and IDLE.
